// File: rtl/stage3_host_pkg.sv
// Purpose: shared types and constants for the stage-3 host (FSM states, widths, LFSR seed).
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package stage3_host_pkg;

    localparam int SLIDE_W = 3;
    localparam int BONUS_W = 2;
    localparam int LUCK_W  = 3;

    localparam logic [LUCK_W-1:0] LFSR_SEED = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    // Everything presented to the evaluator for one round.
    typedef struct packed {
        logic [SLIDE_W-1:0] slide;
        logic [SLIDE_W-1:0] timing;
        logic [LUCK_W-1:0]  luck;
        logic [BONUS_W-1:0] bonus;
        logic               pass2;
    } drive_t;

    // Maximal-length 3-bit sequence: 001,010,101,011,111,110,100.
    function automatic logic [LUCK_W-1:0] lfsr_next(input logic [LUCK_W-1:0] l);
        return {l[1:0], l[2] ^ l[1]};
    endfunction

endpackage

// File: rtl/stage3_host_luck_lfsr.sv
// Purpose: internal 3-bit luck generator; only present when STAGE3_LFSR_EN is defined.
// Latency: luck reflects the new value the cycle after adv is sampled.
// Backpressure: none; advances exactly once per adv pulse.
`ifdef STAGE3_LFSR_EN
module luck_lfsr
    import stage3_host_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              adv,
    output logic [LUCK_W-1:0] luck
);

    // Seeded on reset, stepped once per accepted round.
    always_ff @(posedge clk) begin
        if (rst) begin
            luck <= LFSR_SEED;
        end else if (adv) begin
            luck <= lfsr_next(luck);
        end
    end

endmodule
`endif

// File: rtl/stage3_host.sv
// Purpose: accepts a player round, drives the stage-3 evaluator, returns its verdict and keeps round/win counts.
// Latency: res_valid rises two cycles after in_valid is presented in IDLE (accept edge, one settle cycle, result edge).
// Backpressure: in_ready only in IDLE; result and drive outputs held until res_ready. Luck source: internal LFSR when STAGE3_LFSR_EN is defined, else luck_in.
module stage3_host
    import stage3_host_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SLIDE_W-1:0] in_slide,
    input  logic [SLIDE_W-1:0] in_timing,
    input  logic [BONUS_W-1:0] in_bonus2,
    input  logic               in_pass2,
    input  logic [LUCK_W-1:0]  luck_in,
    output logic [SLIDE_W-1:0] slide,
    output logic [SLIDE_W-1:0] timing,
    output logic [LUCK_W-1:0]  luck3,
    output logic [BONUS_W-1:0] bonus2,
    output logic               pass2,
    input  logic               pass3,
    output logic               res_valid,
    output logic               res_pass,
    input  logic               res_ready,
    output logic [7:0]         round_cnt,
    output logic [7:0]         win_cnt
);

    state_t            state;
    state_t            state_nxt;
    drive_t            drv;
    logic              accept;
    logic              fire;
    logic              settle_done;
    logic [LUCK_W-1:0] luck_cur;

`ifdef STAGE3_LFSR_EN
    // Current LFSR value is captured on the same edge that steps it.
    luck_lfsr u_luck_lfsr (
        .clk  (clk),
        .rst  (rst),
        .adv  (accept),
        .luck (luck_cur)
    );
`else
    assign luck_cur = luck_in;
`endif

    // Next state and handshake decode; in_valid/res_ready only matter in their own state.
    always_comb begin
        state_nxt   = state;
        in_ready    = 1'b0;
        accept      = 1'b0;
        fire        = 1'b0;
        settle_done = 1'b0;
        unique case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                settle_done = 1'b1;
                state_nxt   = ST_RESP;
            end
            ST_RESP: begin
                if (res_ready) begin
                    fire      = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register; reset discards any in-flight round.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Drive registers load only on accept, so they stay frozen through DRIVE and RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            drv <= '0;
        end else if (accept) begin
            drv.slide  <= in_slide;
            drv.timing <= in_timing;
            drv.luck   <= luck_cur;
            drv.bonus  <= in_bonus2;
            drv.pass2  <= in_pass2;
        end
    end

    // Verdict is sampled after the settle cycle and held until the result is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_pass  <= 1'b0;
        end else if (settle_done) begin
            res_valid <= 1'b1;
            res_pass  <= pass3;
        end else if (fire) begin
            res_valid <= 1'b0;
        end
    end

    // Counters update only when a result is consumed; wins saturate, rounds wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            round_cnt <= 8'd0;
            win_cnt   <= 8'd0;
        end else if (fire) begin
            round_cnt <= round_cnt + 8'd1;
            if (res_pass && (win_cnt != 8'hFF)) begin
                win_cnt <= win_cnt + 8'd1;
            end
        end
    end

    assign slide  = drv.slide;
    assign timing = drv.timing;
    assign luck3  = drv.luck;
    assign bonus2 = drv.bonus;
    assign pass2  = drv.pass2;

endmodule

// File: tb/tb_stage3_host.sv
// Purpose: self-checking bench for stage3_host with a behavioural stage-3 evaluator on the drive path.
// Latency: checks res_valid two cycles after in_valid is presented.
// Backpressure: exercises held results, ignored in_valid and early res_ready.
module tb_stage3_host;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_slide;
    logic [2:0] in_timing;
    logic [1:0] in_bonus2;
    logic       in_pass2;
    logic [2:0] luck_in;
    logic [2:0] slide;
    logic [2:0] timing;
    logic [2:0] luck3;
    logic [1:0] bonus2;
    logic       pass2;
    logic       pass3;
    logic       res_valid;
    logic       res_pass;
    logic       res_ready;
    logic [7:0] round_cnt;
    logic [7:0] win_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int     m_rounds = 0;
    int     m_wins   = 0;
    int     m_lidx   = 0;
    logic [2:0] luck_seq [7];

    always #5 clk = ~clk;

    // Stage-3 evaluator: pass needs stage-2 pass and slide (optionally plus bonus) landing on timing.
    function automatic logic eval3(input logic [2:0] s, input logic [2:0] t,
                                   input logic [1:0] b, input logic p2);
        int sum;
        sum = int'(s) + int'(b);
        return p2 && ((s == t) || (sum == int'(t)));
    endfunction

    assign pass3 = eval3(slide, timing, bonus2, pass2);

    stage3_host dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_slide  (in_slide),
        .in_timing (in_timing),
        .in_bonus2 (in_bonus2),
        .in_pass2  (in_pass2),
        .luck_in   (luck_in),
        .slide     (slide),
        .timing    (timing),
        .luck3     (luck3),
        .bonus2    (bonus2),
        .pass2     (pass2),
        .pass3     (pass3),
        .res_valid (res_valid),
        .res_pass  (res_pass),
        .res_ready (res_ready),
        .round_cnt (round_cnt),
        .win_cnt   (win_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] model_luck(input logic [2:0] li);
        logic [2:0] l;
`ifdef STAGE3_LFSR_EN
        l = luck_seq[m_lidx];
        m_lidx = (m_lidx + 1) % 7;
`else
        l = li;
`endif
        return l;
    endfunction

    task automatic model_reset();
        m_rounds = 0;
        m_wins   = 0;
        m_lidx   = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // One complete round: accept, settle, result held for 'stall' cycles, then consumed.
    task automatic run_round(input logic [2:0] s, input logic [2:0] t, input logic [1:0] b,
                             input logic p2, input logic [2:0] li, input int stall,
                             input logic exp_pass);
        logic [2:0] el;
        int         rc0;
        el  = model_luck(li);
        rc0 = m_rounds;
        check("in_ready_idle", in_ready, 1);
        in_valid  = 1'b1;
        in_slide  = s;
        in_timing = t;
        in_bonus2 = b;
        in_pass2  = p2;
        luck_in   = li;
        res_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        in_valid  = 1'b0;
        in_slide  = 3'($urandom);
        in_timing = 3'($urandom);
        in_bonus2 = 2'($urandom);
        in_pass2  = 1'($urandom);
        luck_in   = 3'($urandom);
        check("in_ready_drive", in_ready, 0);
        check("res_valid_drive", res_valid, 0);
        check("slide", slide, s);
        check("timing", timing, t);
        check("bonus2", bonus2, b);
        check("pass2", pass2, p2);
        check("luck3", luck3, el);
        @(posedge clk); #1;
        check("res_valid_resp", res_valid, 1);
        check("res_pass", res_pass, exp_pass);
        check("round_cnt_early_ready", round_cnt, 32'(rc0));
        for (int i = 0; i < stall; i++) begin
            res_ready = 1'b0;
            in_valid  = 1'($urandom);
            @(posedge clk); #1;
            check("stall_res_valid", res_valid, 1);
            check("stall_res_pass", res_pass, exp_pass);
            check("stall_slide", slide, s);
            check("stall_luck3", luck3, el);
            check("stall_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        m_rounds = (m_rounds + 1) % 256;
        if (exp_pass && m_wins < 255) m_wins++;
        check("res_valid_done", res_valid, 0);
        check("in_ready_done", in_ready, 1);
        check("round_cnt", round_cnt, 32'(m_rounds));
        check("win_cnt", win_cnt, 32'(m_wins));
    endtask

    typedef struct {
        logic [2:0] s;
        logic [2:0] t;
        logic [1:0] b;
        logic       p2;
        logic [2:0] li;
        logic       exp_pass;
    } vec_t;

    vec_t vecs [8];

    initial begin
        luck_seq = '{3'b001, 3'b010, 3'b101, 3'b011, 3'b111, 3'b110, 3'b100};
        vecs[0] = '{3'd5, 3'd5, 2'd0, 1'b1, 3'b110, 1'b1};
        vecs[1] = '{3'd5, 3'd5, 2'd0, 1'b0, 3'b011, 1'b0};
        vecs[2] = '{3'd2, 3'd4, 2'd2, 1'b1, 3'b000, 1'b1};
        vecs[3] = '{3'd3, 3'd6, 2'd1, 1'b1, 3'b111, 1'b0};
        vecs[4] = '{3'd7, 3'd1, 2'd2, 1'b1, 3'b101, 1'b0};
        vecs[5] = '{3'd0, 3'd0, 2'd3, 1'b1, 3'b010, 1'b1};
        vecs[6] = '{3'd6, 3'd7, 2'd1, 1'b0, 3'b100, 1'b0};
        vecs[7] = '{3'd1, 3'd3, 2'd2, 1'b1, 3'b001, 1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_slide  = 3'd0;
        in_timing = 3'd0;
        in_bonus2 = 2'd0;
        in_pass2  = 1'b0;
        luck_in   = 3'd0;
        res_ready = 1'b0;
        do_reset();

        // Reset state
        check("rst_in_ready", in_ready, 1);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_pass", res_pass, 0);
        check("rst_round_cnt", round_cnt, 0);
        check("rst_win_cnt", win_cnt, 0);
        check("rst_luck3", luck3, 0);
        check("rst_slide", slide, 0);

        // Table rounds; eight rounds cover the full LFSR period plus wrap to 001.
        for (int i = 0; i < 8; i++) begin
            run_round(vecs[i].s, vecs[i].t, vecs[i].b, vecs[i].p2, vecs[i].li, i % 2,
                      vecs[i].exp_pass);
        end

        // Long stall in RESP with in_valid pulses ignored.
        run_round(3'd4, 3'd4, 2'd1, 1'b1, 3'b110, 10, 1'b1);

        // Reset during DRIVE discards the round and reseeds.
        check("pre_rst_in_ready", in_ready, 1);
        in_valid  = 1'b1;
        in_slide  = 3'd6;
        in_timing = 3'd6;
        in_bonus2 = 2'd1;
        in_pass2  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("mid_drive_in_ready", in_ready, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        check("drv_rst_in_ready", in_ready, 1);
        check("drv_rst_res_valid", res_valid, 0);
        check("drv_rst_round_cnt", round_cnt, 0);
        check("drv_rst_win_cnt", win_cnt, 0);
        check("drv_rst_slide", slide, 0);
        check("drv_rst_luck3", luck3, 0);
        run_round(3'd5, 3'd5, 2'd0, 1'b1, 3'b110, 0, 1'b1);
`ifdef STAGE3_LFSR_EN
        check("reseed_luck3", luck3, 3'b001);
`else
        check("luck_in_luck3", luck3, 3'b110);
`endif

        // Randomized rounds against the model.
        for (int i = 0; i < 40; i++) begin
            logic [2:0] s, t, li;
            logic [1:0] b;
            logic       p2;
            s  = 3'($urandom);
            t  = ($urandom_range(0, 1) == 1) ? s : 3'($urandom);
            b  = 2'($urandom);
            p2 = ($urandom_range(0, 3) != 0);
            li = 3'($urandom);
            run_round(s, t, b, p2, li, $urandom_range(0, 3), eval3(s, t, b, p2));
        end

        // 256 winning rounds from reset: rounds wrap, wins saturate.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            run_round(3'd3, 3'd3, 2'd0, 1'b1, 3'($urandom), 0, 1'b1);
        end
        check("wrap_round_cnt", round_cnt, 0);
        check("sat_win_cnt", win_cnt, 255);
        run_round(3'd2, 3'd2, 2'd0, 1'b1, 3'b000, 0, 1'b1);
        check("sat_hold_win_cnt", win_cnt, 255);
        check("post_wrap_round_cnt", round_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stage3_host.md
STAGE3_HOST -- requirements
Module: stage3_host

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: in_valid  input  1  player round request valid.
REQ-004 SHALL have port: in_ready  output  1  block can accept a round.
REQ-005 SHALL have ports: in_slide, in_timing  input  3 each  player slide/timing codes.
REQ-006 SHALL have ports: in_bonus2  input  2; in_pass2  input  1  carried results from stage 2.
REQ-007 SHALL have port: luck_in  input  3  external luck value, used only when STAGE3_LFSR_EN is undefined.
REQ-008 SHALL have ports: slide, timing, luck3  output  3 each; bonus2  output  2; pass2  output  1  registered drive to the stage-3 evaluator.
REQ-009 SHALL have port: pass3  input  1  evaluator verdict, combinational from the driven outputs.
REQ-010 SHALL have ports: res_valid  output  1; res_pass  output  1; res_ready  input  1  result handshake.
REQ-011 SHALL have ports: round_cnt, win_cnt  output  8 each  rounds played / rounds passed.

Function
REQ-012 SHALL implement FSM IDLE -> DRIVE -> RESP -> IDLE; in_ready = 1 only in IDLE.
REQ-013 SHALL accept a round on in_valid && in_ready: capture in_slide, in_timing, in_bonus2, in_pass2 and the current luck value into the drive registers, then go to DRIVE.
REQ-014 In DRIVE, SHALL hold the drive outputs stable for one cycle of evaluator settle time, then go to RESP.
REQ-015 On entry to RESP, SHALL register pass3 into res_pass and assert res_valid; result latency is accept edge + 2 cycles.
REQ-016 SHALL hold res_valid, res_pass and the drive outputs stable in RESP until res_ready = 1.
REQ-017 On res_valid && res_ready, SHALL return to IDLE, deassert res_valid, increment round_cnt, and increment win_cnt when res_pass = 1.
REQ-018 round_cnt SHALL wrap 255 -> 0; win_cnt SHALL saturate at 255.
REQ-019 in_valid outside IDLE SHALL be ignored, with no capture and no stall effect.
REQ-020 res_ready asserted outside RESP SHALL have no effect.
REQ-021 When the acceptance and the res_ready cycle are back to back, the earliest next accept SHALL be the cycle after returning to IDLE; throughput is at most one round per 3 cycles.

Reset
REQ-022 On rst = 1 at a clock edge: state = IDLE; all drive outputs, res_valid, res_pass, round_cnt and win_cnt = 0; LFSR = 3'b001.
REQ-023 Reset SHALL take priority over every other event, including mid-DRIVE or mid-RESP; any in-flight round is discarded and not counted.

Configuration
REQ-024 With STAGE3_LFSR_EN defined, luck SHALL come from an internal 3-bit LFSR: next = {l[1:0], l[2]^l[1]}, seed 001, period 7 (001,010,101,011,111,110,100); it advances once per accepted round, after its current value is captured.
REQ-025 Without STAGE3_LFSR_EN, luck SHALL be luck_in sampled at the accept edge, and no LFSR logic SHALL exist.

Structure
REQ-026 A shared package SHALL hold the FSM state enum, the LFSR seed (3'b001), and the widths SLIDE_W = 3 and BONUS_W = 2.
REQ-027 The LFSR SHALL be one sub-module, luck_lfsr (clk, rst, adv, luck[2:0]); the FSM and counters stay in stage3_host.

Verification (bench instantiates the stage3 evaluator on the drive/pass3 path, STAGE3_LFSR_EN defined unless stated)
REQ-028 Reset, then round slide=5, timing=5, bonus2=0, pass2=1 -> luck3=001, res_valid at accept+2, res_pass=1, round_cnt=1, win_cnt=1.
REQ-029 Round with pass2=0 (other fields as in REQ-028) -> res_pass=0, win_cnt unchanged, round_cnt incremented.
REQ-030 Seven accepted rounds -> luck3 sequence 001,010,101,011,111,110,100, then 001 again on round 8.
REQ-031 res_ready held low 10 cycles in RESP -> res_valid, res_pass and drive outputs stable; in_valid pulses during this time are ignored.
REQ-032 rst pulsed in DRIVE -> next cycle: IDLE, in_ready=1, res_valid=0, counters=0, LFSR=001.
REQ-033 Without STAGE3_LFSR_EN, luck_in=3'b110 at accept -> luck3=110; 256 winning rounds -> round_cnt=0, win_cnt=255.
